mdu_iterative: RTL and testbench

//  Multi-cycle multiply/divide unit (MDU) owning the HI/LO register pair; it executes the

---
 rtl/mdu_iterative_if.sv | 25 ++
 rtl/mdu_iterative.sv | 199 +++++++++++++++++++
 tb/tb_mdu_iterative.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// Issue/completion bundle between the EX stage and the iterative multiply/divide unit.
// The issuer (EX stage) is the master; the MDU is the slave.
interface mdu_iterative_if #(
    parameter int W = 32
);
    logic         start;
    logic [2:0]   mdu_op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, mdu_op, op1, op2, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mdu_op, op1, op2, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MDU owning HI/LO: 1-bit/cycle shift-add multiply and restoring divide.
// Optional feature macro: MDU_MADD_EN (op 111 = MADD accumulate; otherwise op 111 is a NOP).
module mdu_iterative #(
    parameter int W  = 32,
    parameter int CW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mdu_iterative_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    // acc: product high half / partial remainder; sh: multiplier->product low / dividend->quotient
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           madd_q, madd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic [W:0]     mul_upper_s;
    logic [W-1:0]   mul_acc_nx_s, mul_sh_nx_s;
    logic [W:0]     div_shift_s;
    logic [W-1:0]   div_diff_s;
    logic           div_ge_s;
    logic [W-1:0]   div_acc_nx_s, div_sh_nx_s;
    logic [2*W-1:0] prod_mag_s, prod_sgn_s, mul_res_s;
    logic [W-1:0]   quo_res_s, rem_res_s;
    logic           madd_ok_s;
    logic           sgn_s;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        mag = v[W-1] ? ({W{1'b0}} - v) : v;
    endfunction

`ifdef MDU_MADD_EN
    assign madd_ok_s = 1'b1;
`else
    assign madd_ok_s = 1'b0;
`endif

    assign sgn_s = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_MADD);

    // One iteration of each datapath plus the final sign/accumulate fix-up.
    always_comb begin
        mul_upper_s  = sh_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
        mul_acc_nx_s = mul_upper_s[W:1];
        mul_sh_nx_s  = {mul_upper_s[0], sh_q[W-1:1]};
        div_shift_s  = {acc_q, sh_q[W-1]};
        div_ge_s     = (div_shift_s >= {1'b0, opb_q});
        // Only used when div_ge_s, so the true difference already fits in W bits.
        div_diff_s   = div_shift_s[W-1:0] - opb_q;
        div_acc_nx_s = div_ge_s ? div_diff_s : div_shift_s[W-1:0];
        div_sh_nx_s  = {sh_q[W-2:0], div_ge_s};
        prod_mag_s   = {mul_acc_nx_s, mul_sh_nx_s};
        prod_sgn_s   = neg_q ? ({(2*W){1'b0}} - prod_mag_s) : prod_mag_s;
        mul_res_s    = madd_q ? ({hi_q, lo_q} + prod_sgn_s) : prod_sgn_s;
        quo_res_s    = neg_q ? ({W{1'b0}} - div_sh_nx_s) : div_sh_nx_s;
        rem_res_s    = rneg_q ? ({W{1'b0}} - div_acc_nx_s) : div_acc_nx_s;
    end

    // Next-state, operand latch, iteration and HI/LO write control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        madd_d  = madd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.flush) begin
                    case (bus.mdu_op)
                        OP_MULT, OP_MULTU, OP_MADD: begin
                            if ((bus.mdu_op != OP_MADD) || madd_ok_s) begin
                                state_d = ST_MUL;
                                busy_d  = 1'b1;
                                cnt_d   = CW'(W - 1);
                                acc_d   = {W{1'b0}};
                                opb_d   = sgn_s ? mag(bus.op1) : bus.op1;
                                sh_d    = sgn_s ? mag(bus.op2) : bus.op2;
                                neg_d   = sgn_s && (bus.op1[W-1] ^ bus.op2[W-1]);
                                rneg_d  = 1'b0;
                                madd_d  = (bus.mdu_op == OP_MADD);
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV;
                            busy_d  = 1'b1;
                            cnt_d   = CW'(W - 1);
                            acc_d   = {W{1'b0}};
                            sh_d    = sgn_s ? mag(bus.op1) : bus.op1;
                            opb_d   = sgn_s ? mag(bus.op2) : bus.op2;
                            // A zero divisor yields an all-ones quotient that must not be negated.
                            neg_d   = sgn_s && (bus.op2 != {W{1'b0}}) && (bus.op1[W-1] ^ bus.op2[W-1]);
                            rneg_d  = sgn_s && bus.op1[W-1];
                            madd_d  = 1'b0;
                        end
                        OP_MTHI: hi_d = bus.op1;
                        OP_MTLO: lo_d = bus.op1;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = (state_q == ST_MUL) ? mul_acc_nx_s : div_acc_nx_s;
                    sh_d  = (state_q == ST_MUL) ? mul_sh_nx_s : div_sh_nx_s;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (state_q == ST_MUL) begin
                            {hi_d, lo_d} = mul_res_s;
                        end else begin
                            hi_d = rem_res_s;
                            lo_d = quo_res_s;
                        end
                    end else begin
                        cnt_d  = cnt_q - CW'(1);
                        busy_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            acc_q   <= {W{1'b0}};
            sh_q    <= {W{1'b0}};
            opb_q   <= {W{1'b0}};
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            madd_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= {W{1'b0}};
            lo_q    <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            madd_q  <= madd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: scoreboard of expected {hi,lo} per issued op.
module tb_mdu_iterative;
    localparam int W = 32;
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] model_hilo;

    mdu_iterative_if #(.W(W)) bus ();
    mdu_iterative #(.W(W), .CW(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [2*W-1:0] cur);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = cur;
        case (op)
            OP_MULT:  model = sa * sb;
            OP_MULTU: model = {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: model = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            OP_MADD: model = cur + (sa * sb);
            default: model = cur;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [2*W-1:0] exp);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.op1    = a;
        bus.op2    = b;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = OP_NOP;
        bus.op1    = 32'($urandom);
        bus.op2    = 32'($urandom);
    endtask

    task automatic wait_done(output bit ok, output int nbusy);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        int nb;
        logic [2*W-1:0] e;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_DIV, 32'd1000, 32'd7, 1'b0, 64'h0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_hilo = 64'h0;
        @(negedge clk);
        issue(OP_MULTU, 32'd6, 32'd7, 1'b1, 64'd42);
        wait_done(ok, nb);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            exp_q.delete();
            $display("FAIL after_reset_op: no done within bound, required done");
        end else begin
            e = exp_q.pop_front();
            if ({bus.hi, bus.lo} !== e) begin
                tests_failed++;
                $display("FAIL after_reset_op: got %h, required %h", {bus.hi, bus.lo}, e);
            end
            model_hilo = e;
        end
    endtask

    // Directed MULT/DIV vectors: latency and result per vector.
    task automatic test_arith();
        logic [2:0]     op_t [10] = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULT, OP_DIV,
                                      OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [W-1:0]   a_t  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF9,
                                      32'd100, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFFB};
        logic [W-1:0]   b_t  [10] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd2,
                                      32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'd0};
        logic [2*W-1:0] r_t  [10] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                                      64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
                                      64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF,
                                      64'h0000_0000_8000_0000, 64'h0000_0002_0000_000E,
                                      64'h0000_0001_FFFF_FFFD, 64'hFFFF_FFFB_FFFF_FFFF};
        bit ok;
        int nb;
        logic [2*W-1:0] e;
        for (int i = 0; i < 10; i++) begin
            issue(op_t[i], a_t[i], b_t[i], 1'b1, r_t[i]);
            wait_done(ok, nb);
            tests_run++;
            if (!ok || nb != 32) begin
                tests_failed++;
                $display("FAIL arith_latency[%0d]: done=%b busy_cycles=%0d, required done after 32 busy cycles", i, ok, nb);
            end
            if (!ok) begin
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if ({bus.hi, bus.lo} !== e) begin
                    tests_failed++;
                    $display("FAIL arith_value[%0d]: got %h, required %h", i, {bus.hi, bus.lo}, e);
                end
                model_hilo = e;
            end
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int nb;
        int extra;
        logic [2*W-1:0] e;
        issue(OP_MULTU, 32'd3, 32'd5, 1'b1, 64'd15);
        bus.start = 1'b1; bus.mdu_op = OP_DIVU; bus.op1 = 32'd1000; bus.op2 = 32'd3;
        repeat (2) @(negedge clk);
        bus.start = 1'b0; bus.mdu_op = OP_NOP;
        wait_done(ok, nb);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            exp_q.delete();
            $display("FAIL busy_ignore: no done within bound, required done");
        end else begin
            e = exp_q.pop_front();
            if ({bus.hi, bus.lo} !== e) begin
                tests_failed++;
                $display("FAIL busy_ignore: got %h, required %h", {bus.hi, bus.lo}, e);
            end
            model_hilo = e;
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL busy_ignore_second: %0d busy/done cycles seen, required 0", extra);
        end
    endtask

    task automatic test_flush();
        int extra;
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, 64'h0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_busy: busy=%b, required 0", bus.busy);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) extra++;
            @(negedge clk);
        end
        tests_run++;
        if (extra != 0 || {bus.hi, bus.lo} !== model_hilo) begin
            tests_failed++;
            $display("FAIL flush_mid: done_pulses=%0d hilo=%h, required 0 and %h", extra, {bus.hi, bus.lo}, model_hilo);
        end
        issue(OP_MULTU, 32'd7, 32'd9, 1'b0, 64'h0);
        repeat (31) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_final_busy: busy=%b in last iteration, required 1", bus.busy);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.hi, bus.lo} !== model_hilo) begin
            tests_failed++;
            $display("FAIL flush_final: done=%b busy=%b hilo=%h, required 0 0 %h", bus.done, bus.busy, {bus.hi, bus.lo}, model_hilo);
        end
    endtask

    task automatic test_flush_start();
        int extra;
        bus.flush = 1'b1;
        issue(OP_MTHI, 32'h0000_DEAD, 32'h0, 1'b0, 64'h0);
        bus.flush = 1'b0;
        tests_run++;
        if (bus.hi !== model_hilo[63:32] || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_start_mthi: hi=%h busy=%b, required %h 0", bus.hi, bus.busy, model_hilo[63:32]);
        end
        bus.flush = 1'b1;
        issue(OP_MULTU, 32'd11, 32'd13, 1'b0, 64'h0);
        bus.flush = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy === 1'b1 || bus.done === 1'b1) extra++;
            @(negedge clk);
        end
        tests_run++;
        if (extra != 0 || {bus.hi, bus.lo} !== model_hilo) begin
            tests_failed++;
            $display("FAIL flush_start_mul: busy/done cycles=%0d hilo=%h, required 0 %h", extra, {bus.hi, bus.lo}, model_hilo);
        end
    endtask

    task automatic test_mthi_madd();
        bit ok;
        int nb;
        int extra;
        logic [2*W-1:0] e;
        issue(OP_MTLO, 32'h0, 32'h0, 1'b0, 64'h0);
        issue(OP_MTHI, 32'h0000_1234, 32'h0, 1'b0, 64'h0);
        model_hilo = 64'h0000_1234_0000_0000;
        tests_run++;
        if ({bus.hi, bus.lo} !== model_hilo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mthi_mtlo: hilo=%h busy=%b done=%b, required %h 0 0", {bus.hi, bus.lo}, bus.busy, bus.done, model_hilo);
        end
`ifdef MDU_MADD_EN
        issue(OP_MADD, 32'd2, 32'd3, 1'b1, 64'h0000_1234_0000_0006);
        issue(OP_NOP, 32'h0, 32'h0, 1'b0, 64'h0);
        wait_done(ok, nb);
        tests_run++;
        if (!ok || nb != 31) begin
            tests_failed++;
            $display("FAIL madd_latency: done=%b busy_cycles=%0d, required done after 31 remaining busy cycles", ok, nb);
        end
        if (!ok) begin
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.hi, bus.lo} !== e) begin
                tests_failed++;
                $display("FAIL madd_value: got %h, required %h", {bus.hi, bus.lo}, e);
            end
            model_hilo = e;
        end
        extra = 0;
`else
        e = model_hilo;
        issue(OP_MADD, 32'd2, 32'd3, 1'b0, 64'h0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b1 || bus.done === 1'b1) extra++;
            @(negedge clk);
        end
        wait_done(ok, nb);
        tests_run++;
        if (extra != 0 || ok || {bus.hi, bus.lo} !== e) begin
            tests_failed++;
            $display("FAIL madd_disabled: busy/done cycles=%0d hilo=%h, required 0 %h", extra, {bus.hi, bus.lo}, e);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0]     ops [5] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD};
        logic [2:0]     op;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] e;
        bit ok;
        int nb;
        int nops;
`ifdef MDU_MADD_EN
        nops = 5;
`else
        nops = 4;
`endif
        for (int i = 0; i < 8; i++) begin
            op = ops[$urandom_range(0, nops - 1)];
            a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            issue(op, a, b, 1'b1, model(op, a, b, model_hilo));
            wait_done(ok, nb);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                exp_q.delete();
                $display("FAIL b2b[%0d]: no done within bound, required done", i);
                break;
            end
            e = exp_q.pop_front();
            if ({bus.hi, bus.lo} !== e || nb != 32) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: op=%0d a=%h b=%h got %h busy=%0d, required %h busy=32", i, op, a, b, {bus.hi, bus.lo}, nb, e);
            end
            model_hilo = e;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_hilo   = 64'h0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.mdu_op   = OP_NOP;
        bus.op1      = 32'h0;
        bus.op2      = 32'h0;
        bus.flush    = 1'b0;
        #3;
        test_reset();
        test_arith();
        test_busy_ignore();
        test_flush();
        test_flush_start();
        test_mthi_madd();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
